// File: rtl/npu_pkg.sv
// Shared NPU datapath types and defaults for the convolution window buffer and MAC array.
// Optional build macro used by the window buffer: LINEBUF_STRIDE_EN (column stride support).
package npu_pkg;

  localparam int DEF_BIT_DEPTH = 8;
  localparam int DEF_K         = 3;
  localparam int DEF_IMG_W     = 32;

  typedef logic [DEF_BIT_DEPTH-1:0] pixel_t;

  // Flat index of window element (r,c); c=0 is the oldest column.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/win_ctrl.sv
// Window control: column position, fill level, optional stride gating and the output handshake.
// Build macro LINEBUF_STRIDE_EN adds the stride input and stride_cnt.
module win_ctrl
  import npu_pkg::*;
#(
  parameter int K     = DEF_K,
  parameter int IMG_W = DEF_IMG_W,
  parameter int CNT_W = $clog2(IMG_W)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic       out_ready,
`ifdef LINEBUF_STRIDE_EN
  input  logic [1:0] stride,
`endif
  output logic       in_ready,
  output logic       accept,
  output logic       emit,
  output logic       out_valid,
  output logic       out_last
);

  localparam int FILL_W = $clog2(K + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(K);
  localparam logic [CNT_W-1:0]  COL_LAST  = CNT_W'(IMG_W - 1);

  logic [CNT_W-1:0]  col_q, col_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              last_col, complete;
`ifdef LINEBUF_STRIDE_EN
  logic [1:0]        stride_q, stride_d, stride_eff;
`endif

  // valid/ready: a beat transfers on a rising edge where valid && ready; a valid producer holds
  // its data until that edge. A single output stage means input is taken whenever the
  // output register is empty or being drained in the same cycle.
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready && !clear;
    last_col    = (col_q == COL_LAST);
    fill_inc    = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    complete    = accept && (fill_inc == FILL_FULL);
`ifdef LINEBUF_STRIDE_EN
    stride_eff  = (stride == 2'd0) ? 2'd1 : stride;
    emit        = complete && (stride_q == 2'd0);
    stride_d    = stride_q;
`else
    emit        = complete;
`endif
    col_d       = col_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = last_col;
    end
    if (accept) begin
      col_d  = last_col ? '0 : col_q + 1'b1;
      fill_d = last_col ? '0 : fill_inc;
    end
`ifdef LINEBUF_STRIDE_EN
    if (complete) stride_d = (stride_q == 2'd0) ? stride_eff - 2'd1 : stride_q - 2'd1;
    if (accept && last_col) stride_d = 2'd0;
`endif

    // A clear wins over a same-cycle accept: the offered column is dropped.
    if (clear) begin
      col_d       = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
`ifdef LINEBUF_STRIDE_EN
      stride_d    = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef LINEBUF_STRIDE_EN
      stride_q    <= 2'd0;
`endif
    end else begin
      col_q       <= col_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef LINEBUF_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: rtl/conv_window_buffer.sv
// KxK sliding-window buffer: shifts one K-pixel column per accepted beat, emits full windows.
// Build macro LINEBUF_STRIDE_EN enables the stride input (column stride 1..3).
module conv_window_buffer
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int K         = DEF_K,
  parameter int IMG_W     = DEF_IMG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K*BIT_DEPTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [K*K*BIT_DEPTH-1:0] out_win,
`ifdef LINEBUF_STRIDE_EN
  input  logic [1:0]               stride,
`endif
  output logic                     out_last
);

  localparam int CNT_W = $clog2(IMG_W);

  logic [BIT_DEPTH-1:0] win_q[K][K], win_d[K][K];
  logic [BIT_DEPTH-1:0] out_q[K][K], out_d[K][K];
  logic                 accept, emit;

  win_ctrl #(
    .K     (K),
    .IMG_W (IMG_W),
    .CNT_W (CNT_W)
  ) u_win_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .out_ready (out_ready),
`ifdef LINEBUF_STRIDE_EN
    .stride    (stride),
`endif
    .in_ready  (in_ready),
    .accept    (accept),
    .emit      (emit),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  // The output register captures the post-shift window so it appears the cycle after the accept.
  always_comb begin
    win_d = win_q;
    out_d = out_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = in_data[r*BIT_DEPTH +: BIT_DEPTH];
      end
    end
    if (emit) out_d = win_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
          out_q[r][c] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
      out_q <= out_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign out_win[idx(r, c, K)*BIT_DEPTH +: BIT_DEPTH] = out_q[r][c];
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer (K=3, BIT_DEPTH=8, IMG_W=8) against a row-level model.
module tb_conv_window_buffer;

  localparam int BD    = 8;
  localparam int K     = 3;
  localparam int IMG_W = 8;
  localparam int COL_W = K * BD;
  localparam int WIN_W = K * K * BD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [COL_W-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIN_W-1:0] out_win;
  logic             out_last;
  logic [1:0]       stride = 2'd1;

  int               n_chk = 0;
  int               n_pass = 0;
  int               win_cnt = 0;
  int               rdy_mode = 0;
  int               stride_m = 1;
  logic [COL_W-1:0] row_cols[$];
  logic [WIN_W:0]   exp_q[$];
  bit               stall_prev = 1'b0;
  logic [WIN_W:0]   stall_word = '0;

  conv_window_buffer #(.BIT_DEPTH(BD), .K(K), .IMG_W(IMG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win),
`ifdef LINEBUF_STRIDE_EN
    .stride    (stride),
`endif
    .out_last  (out_last)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference model: a row is a list of columns; a window is the last K of them
  function automatic logic [WIN_W:0] make_win(input int p, input bit last);
    logic [WIN_W-1:0] w;
    logic [COL_W-1:0] col;
    w = '0;
    for (int c = 0; c < K; c++) begin
      col = row_cols[p - (K - 1) + c];
      for (int r = 0; r < K; r++) w[(r*K + c)*BD +: BD] = col[r*BD +: BD];
    end
    return {last, w};
  endfunction

  task automatic model_accept(input logic [COL_W-1:0] d);
    int p;
    row_cols.push_back(d);
    p = row_cols.size() - 1;
    if (p >= K - 1 && ((p - (K - 1)) % stride_m) == 0) exp_q.push_back(make_win(p, p == IMG_W - 1));
    if (p == IMG_W - 1) row_cols.delete();
  endtask

  task automatic model_restart();
    row_cols.delete();
    exp_q.delete();
  endtask

  // downstream ready: 0 = always ready, 1 = random, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_window", {out_last, out_win}, stall_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", {out_last, out_win}, '1);
        end else begin
          chk("window", {out_last, out_win}, exp_q.pop_front());
          win_cnt++;
        end
      end
      stall_prev = out_valid && !out_ready && !clear;
      stall_word = {out_last, out_win};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic send_col(input logic [COL_W-1:0] d);
    int  n;
    bit  acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        model_accept(d);
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear(input bit with_valid);
    clear    = 1'b1;
    in_valid = with_valid;
    in_data  = COL_W'($urandom());
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_restart();
    chk("clear_out_valid", out_valid, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [COL_W-1:0] ramp_col(input int j);
    logic [COL_W-1:0] v;
    for (int r = 0; r < K; r++) v[r*BD +: BD] = BD'(j*16 + r);
    return v;
  endfunction

  initial begin
    int base;
    bit hold_ok;

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_win", out_win, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // directed ramp row: latency, contents and out_last placement
    base = win_cnt;
    for (int j = 0; j < IMG_W; j++) begin
      send_col(ramp_col(j));
      chk("ramp_latency", out_valid, j >= K - 1);
      chk("ramp_last", out_last, j == IMG_W - 1);
      if (j == K - 1) begin
        chk("ramp_first_00", out_win[0 +: BD], 8'h00);
        chk("ramp_first_02", out_win[2*BD +: BD], 8'h20);
      end
    end
    wait_drain();
    chk("ramp_count", win_cnt - base, IMG_W - K + 1);

    // two rows back to back
    base = win_cnt;
    for (int j = 0; j < 2 * IMG_W; j++) send_col(COL_W'($urandom()));
    wait_drain();
    chk("two_row_count", win_cnt - base, 2 * (IMG_W - K + 1));

    // backpressure: stall downstream for 5 cycles after the first window
    base = win_cnt;
    fork
      begin
        for (int j = 0; j < IMG_W; j++) send_col(COL_W'($urandom()));
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        rdy_mode = 2;
        @(negedge clk);
        hold_ok = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (in_ready || !out_valid) hold_ok = 1'b0;
        end
        chk("stall_in_ready_low", hold_ok, 1'b1);
        rdy_mode = 0;
      end
    join
    wait_drain();
    chk("stall_count", win_cnt - base, IMG_W - K + 1);

    // clear with a same-cycle valid column after col 4
    for (int j = 0; j < 5; j++) send_col(COL_W'($urandom()));
    do_clear(1'b1);
    for (int j = 0; j < K; j++) begin
      send_col(COL_W'($urandom()));
      chk("post_clear_fill", out_valid, j == K - 1);
    end
    wait_drain();

    // mid-row reset: restart at column 0
    send_col(COL_W'($urandom()));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_last", out_last, 1'b0);
    model_restart();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    base = win_cnt;
    for (int j = 0; j < IMG_W; j++) send_col(COL_W'($urandom()));
    wait_drain();
    chk("midrst_count", win_cnt - base, IMG_W - K + 1);

`ifdef LINEBUF_STRIDE_EN
    // stride 2: windows ending at cols 2,4,6, none marked last
    do_clear(1'b0);
    stride   = 2'd2;
    stride_m = 2;
    base = win_cnt;
    for (int j = 0; j < IMG_W; j++) send_col(ramp_col(j));
    wait_drain();
    chk("stride2_count", win_cnt - base, 3);
    stride   = 2'd1;
    stride_m = 1;
`endif

    // randomized traffic: random gaps, random backpressure, occasional clear
    rdy_mode = 1;
    for (int n = 0; n < 5 * IMG_W; n++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) do_clear(1'($urandom_range(0, 1)));
      send_col(COL_W'($urandom()));
    end
    rdy_mode = 0;
    wait_drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
